// File: rtl/parallel_rank_sort.sv
// Rank-based parallel sorter: DN x DN compare matrix, popcount ranks, scatter into sorted order.
// Optional trimmed sum of sorted positions TRIM_LO..TRIM_HI via macro PARALLEL_RANK_SORT_TRIM_SUM_EN.
module parallel_rank_sort #(
    parameter int DN      = 25,
    parameter int DW      = 8,
    parameter int IW      = $clog2(DN),
    parameter int DESCEND = 0,
    parameter int TRIM_LO = 2,
    parameter int TRIM_HI = 22
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW*DN-1:0]              data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DW*DN-1:0]              data_sorted,
    output logic [IW*DN-1:0]              index_sorted,
    output logic [DW+$clog2(DN+1)-1:0]    trim_sum
);

    localparam int TW = DW + $clog2(DN + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        RANK = 3'd2,
        SCAT = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0] d_q     [DN];
    logic [DN-1:0] cmp_q   [DN];
    logic [DN-1:0] cmp_nx  [DN];
    logic [IW-1:0] rank_q  [DN];
    logic [IW-1:0] rank_nx [DN];
    logic [IW:0]   rank_cnt;
    logic [DW*DN-1:0] ds_nx;
    logic [IW*DN-1:0] is_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = in_valid ? CMP : IDLE;
            CMP:     state_nx = RANK;
            RANK:    state_nx = SCAT;
            SCAT:    state_nx = HOLD;
            HOLD:    state_nx = out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    // Ties broken by original index: earlier equal elements count as "before", later ones do not.
    always_comb begin
        for (int unsigned i = 0; i < DN; i++) begin
            for (int unsigned j = 0; j < DN; j++) begin
                cmp_nx[i][j] = 1'b0;
                if (j < i)
                    cmp_nx[i][j] = (DESCEND != 0) ? (d_q[j] >= d_q[i]) : (d_q[j] <= d_q[i]);
                else if (j > i)
                    cmp_nx[i][j] = (DESCEND != 0) ? (d_q[j] > d_q[i]) : (d_q[j] < d_q[i]);
            end
        end
    end

    always_comb begin
        rank_cnt = '0;
        for (int unsigned i = 0; i < DN; i++) begin
            rank_cnt = '0;
            for (int unsigned j = 0; j < DN; j++)
                rank_cnt = rank_cnt + (IW+1)'(cmp_q[i][j]);
            rank_nx[i] = rank_cnt[IW-1:0];
        end
    end

    always_comb begin
        ds_nx = '0;
        is_nx = '0;
        for (int unsigned p = 0; p < DN; p++) begin
            for (int unsigned i = 0; i < DN; i++) begin
                if (rank_q[i] == IW'(p)) begin
                    ds_nx[p*DW +: DW] = d_q[i];
                    is_nx[p*IW +: IW] = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DN; i++) begin
                d_q[i]    <= '0;
                cmp_q[i]  <= '0;
                rank_q[i] <= '0;
            end
            data_sorted  <= '0;
            index_sorted <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < DN; k++)
                            d_q[k] <= data_in[k*DW +: DW];
                    end
                end
                CMP:  cmp_q  <= cmp_nx;
                RANK: rank_q <= rank_nx;
                SCAT: begin
                    data_sorted  <= ds_nx;
                    index_sorted <= is_nx;
                end
                default: ;
            endcase
        end
    end

`ifdef PARALLEL_RANK_SORT_TRIM_SUM_EN
    logic [TW-1:0] ts_nx;

    // Window selection by rank is equivalent to summing sorted positions TRIM_LO..TRIM_HI.
    always_comb begin
        ts_nx = '0;
        for (int unsigned i = 0; i < DN; i++) begin
            if (rank_q[i] >= IW'(TRIM_LO) && rank_q[i] <= IW'(TRIM_HI))
                ts_nx = ts_nx + TW'(d_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                trim_sum <= '0;
        else if (state == SCAT) trim_sum <= ts_nx;
    end
`else
    assign trim_sum = '0;
`endif

endmodule
